vga_bw_rx: RTL and testbench

VGA_BW_RX -- requirements
Module: vga_bw_rx

---
 rtl/vga_bw_pkg.sv | 14 +
 rtl/vga_bw_rx_if.sv | 25 ++
 rtl/vga_bw_meas.sv | 42 ++++
 rtl/vga_bw_rx.sv | 93 +++++++++
 tb/tb_vga_bw_rx.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/vga_bw_pkg.sv
// vga_bw_pkg: default VGA timing, counter limits and lock-state encoding
package vga_bw_pkg;
  localparam int DEF_H_DISPLAY     = 640;
  localparam int DEF_H_FRONT_PORCH = 16;
  localparam int DEF_H_SYNC_PULSE  = 96;
  localparam int DEF_H_TOTAL       = 800;
  localparam int DEF_V_DISPLAY     = 480;
  localparam int DEF_V_FRONT_PORCH = 10;
  localparam int DEF_V_SYNC_PULSE  = 2;
  localparam int DEF_V_TOTAL       = 525;
  localparam int DEF_LOCK_FRAMES   = 2;
  localparam logic [9:0] CNT_MAX   = 10'd1023;
  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} lock_state_t;
endpackage

// File: rtl/vga_bw_rx_if.sv
// vga_bw_rx_if: sync/video inputs and recovered pixel stream of the mono VGA receiver
interface vga_bw_rx_if;
  logic       hsync;
  logic       vsync;
  logic       video;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       pix_data;
  logic       pix_valid;
  logic       frame_start;
  logic       locked;
  logic       sync_err;
  logic [9:0] h_total_meas;
  logic [9:0] v_total_meas;
  modport master (
    output hsync, vsync, video,
    input  pix_x, pix_y, pix_data, pix_valid, frame_start, locked, sync_err,
           h_total_meas, v_total_meas
  );
  modport slave (
    input  hsync, vsync, video,
    output pix_x, pix_y, pix_data, pix_valid, frame_start, locked, sync_err,
           h_total_meas, v_total_meas
  );
endinterface

// File: rtl/vga_bw_meas.sv
// vga_bw_meas: measures hsync-to-hsync line length and lines per frame, flags bad lines/frames and hsync loss
module vga_bw_meas
  import vga_bw_pkg::*;
#(
  parameter int H_TOTAL = DEF_H_TOTAL,
  parameter int V_TOTAL = DEF_V_TOTAL
) (
  input  logic       clk_25mhz,
  input  logic       reset_n,
  input  logic       h_rise,
  input  logic       v_rise,
  output logic       line_bad,
  output logic       timeout,
  output logic       frame_bad,
  output logic [9:0] h_total_meas,
  output logic [9:0] v_total_meas
);
  logic [9:0] l_cnt;
  logic [9:0] f_cnt;
  logic       h_prev;
  logic       lines_ok;
  // l_cnt equals the rise-to-rise distance on the cycle the next rise is seen
  assign timeout   = !h_rise && l_cnt == CNT_MAX - 10'd1;
  assign line_bad  = h_rise && h_prev && l_cnt != 10'(H_TOTAL);
  assign frame_bad = v_rise && (f_cnt != 10'(V_TOTAL) || !lines_ok || line_bad || timeout);
  always_ff @(posedge clk_25mhz or negedge reset_n)
    if (!reset_n) begin
      l_cnt        <= '0;
      f_cnt        <= '0;
      h_prev       <= 1'b0;
      lines_ok     <= 1'b0;
      h_total_meas <= '0;
      v_total_meas <= '0;
    end else begin
      l_cnt        <= h_rise ? 10'd1 : l_cnt == CNT_MAX ? CNT_MAX : l_cnt + 10'd1;
      h_prev       <= h_rise || (h_prev && !timeout);
      h_total_meas <= h_rise && h_prev ? l_cnt : timeout ? CNT_MAX : h_total_meas;
      f_cnt        <= v_rise ? {9'd0, h_rise} : h_rise && f_cnt != CNT_MAX ? f_cnt + 10'd1 : f_cnt;
      v_total_meas <= v_rise ? f_cnt : v_total_meas;
      lines_ok     <= (v_rise || lines_ok) && !line_bad && !timeout;
    end
endmodule

// File: rtl/vga_bw_rx.sv
// vga_bw_rx: mono VGA receiver recovering pixel coordinates from hsync/vsync, with frame-lock tracking
module vga_bw_rx
  import vga_bw_pkg::*;
#(
  parameter int H_DISPLAY     = DEF_H_DISPLAY,
  parameter int H_FRONT_PORCH = DEF_H_FRONT_PORCH,
  parameter int H_SYNC_PULSE  = DEF_H_SYNC_PULSE,
  parameter int H_TOTAL       = DEF_H_TOTAL,
  parameter int V_DISPLAY     = DEF_V_DISPLAY,
  parameter int V_FRONT_PORCH = DEF_V_FRONT_PORCH,
  parameter int V_SYNC_PULSE  = DEF_V_SYNC_PULSE,
  parameter int V_TOTAL       = DEF_V_TOTAL,
  parameter int LOCK_FRAMES   = DEF_LOCK_FRAMES
) (
  input logic        clk_25mhz,
  input logic        reset_n,
  vga_bw_rx_if.slave vif
);
  if (H_DISPLAY + H_FRONT_PORCH + H_SYNC_PULSE >= H_TOTAL || H_TOTAL > 1023 ||
      V_DISPLAY + V_FRONT_PORCH + V_SYNC_PULSE >= V_TOTAL || V_TOTAL > 1023) begin : g_bad_timing
    $error("vga_bw_rx: inconsistent timing parameters");
  end
  logic        hs_r, vs_r, vid_r, hs_d, vs_d;
  logic        h_rise, v_rise, h_wrap, vis;
  logic        line_bad, timeout, frame_bad, err_evt;
  logic [9:0]  h_pos, v_pos;
  logic [7:0]  good_cnt, good_nxt;
  lock_state_t state, state_nxt;
  assign h_rise     = hs_r && !hs_d;
  assign v_rise     = vs_r && !vs_d;
  assign h_wrap     = h_pos == 10'(H_TOTAL - 1);
  assign err_evt    = line_bad || timeout || frame_bad;
  assign vis        = state == LOCKED && h_pos < 10'(H_DISPLAY) && v_pos < 10'(V_DISPLAY);
  assign vif.locked = state == LOCKED;
  vga_bw_meas #(.H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL)) u_meas (
    .clk_25mhz    (clk_25mhz),
    .reset_n      (reset_n),
    .h_rise       (h_rise),
    .v_rise       (v_rise),
    .line_bad     (line_bad),
    .timeout      (timeout),
    .frame_bad    (frame_bad),
    .h_total_meas (vif.h_total_meas),
    .v_total_meas (vif.v_total_meas)
  );
  // an error on the same cycle as a frame edge always wins, so the FSM never locks on a bad edge
  always_comb begin
    state_nxt = state;
    good_nxt  = good_cnt;
    if (state == SEARCH) begin
      state_nxt = v_rise ? ACQUIRE : SEARCH;
      good_nxt  = v_rise ? 8'd0 : good_cnt;
    end else if (err_evt)
      state_nxt = SEARCH;
    else if (state == ACQUIRE && v_rise) begin
      good_nxt  = good_cnt + 8'd1;
      state_nxt = good_nxt >= 8'(LOCK_FRAMES) ? LOCKED : ACQUIRE;
    end
  end
  always_ff @(posedge clk_25mhz or negedge reset_n)
    if (!reset_n) begin
      state    <= SEARCH;
      good_cnt <= '0;
    end else begin
      state    <= state_nxt;
      good_cnt <= good_nxt;
    end
  // h_pos reloads one past the sync start so it tracks the column held in vid_r
  always_ff @(posedge clk_25mhz or negedge reset_n)
    if (!reset_n) begin
      {hs_r, vs_r, vid_r, hs_d, vs_d} <= '0;
      h_pos           <= '0;
      v_pos           <= '0;
      vif.sync_err    <= 1'b0;
      vif.pix_x       <= '0;
      vif.pix_y       <= '0;
      vif.pix_data    <= 1'b0;
      vif.pix_valid   <= 1'b0;
      vif.frame_start <= 1'b0;
    end else begin
      {hs_r, vs_r, vid_r} <= {vif.hsync, vif.vsync, vif.video};
      {hs_d, vs_d}        <= {hs_r, vs_r};
      h_pos           <= h_rise ? 10'(H_DISPLAY + H_FRONT_PORCH + 1) : h_wrap ? 10'd0 : h_pos + 10'd1;
      v_pos           <= v_rise ? 10'(V_DISPLAY + V_FRONT_PORCH) : !h_wrap ? v_pos :
                         v_pos == 10'(V_TOTAL - 1) ? 10'd0 : v_pos + 10'd1;
      vif.sync_err    <= state != SEARCH && err_evt;
      vif.pix_x       <= h_pos;
      vif.pix_y       <= v_pos;
      vif.pix_data    <= vis && vid_r;
      vif.pix_valid   <= vis;
      vif.frame_start <= vis && h_pos == 10'd0 && v_pos == 10'd0;
    end
endmodule

// File: tb/tb_vga_bw_rx.sv
// tb_vga_bw_rx: drives a reduced-size mono VGA stream and scoreboards recovered pixels and lock behaviour
module tb_vga_bw_rx;
  localparam int HD = 40, HF = 4, HS = 6, HT = 60;
  localparam int VD = 20, VF = 2, VS = 2, VT = 30;
  typedef struct packed {logic [9:0] x; logic [9:0] y; logic d;} px_t;
  logic clk_25mhz = 1'b0;
  logic reset_n   = 1'b0;
  always #20 clk_25mhz = ~clk_25mhz;
  vga_bw_rx_if vif();
  vga_bw_rx #(
    .H_DISPLAY(HD), .H_FRONT_PORCH(HF), .H_SYNC_PULSE(HS), .H_TOTAL(HT),
    .V_DISPLAY(VD), .V_FRONT_PORCH(VF), .V_SYNC_PULSE(VS), .V_TOTAL(VT),
    .LOCK_FRAMES(2)
  ) dut (
    .clk_25mhz (clk_25mhz),
    .reset_n   (reset_n),
    .vif       (vif)
  );
  int cyc = 0;
  always @(posedge clk_25mhz) cyc <= cyc + 1;
  int n_chk = 0, n_fail = 0;
  px_t sbq[$];
  bit chk_on = 0, stretched = 0;
  logic last_h = 0, last_v = 0, lk_d = 0;
  int err_n = 0, err_cyc = -1, lock_cyc = -1, hs_cyc = -1, vs_cyc = -1, mark_cyc = -1;
  int vcount = 0, fs_count = 0, px_bad = 0;
  logic [9:0] err_htm = '0, err_vtm = '0;

  function automatic logic pat(input int x, input int y);
    return x[2] ^ y[2];
  endfunction

  // monitor: records error/lock events and pops the pixel scoreboard
  initial forever begin
    px_t e;
    @(negedge clk_25mhz);
    if (vif.sync_err === 1'b1) begin
      err_n++; err_cyc = cyc; err_htm = vif.h_total_meas; err_vtm = vif.v_total_meas;
    end
    if (vif.locked === 1'b1 && lk_d !== 1'b1) lock_cyc = cyc;
    lk_d = vif.locked;
    if (chk_on) begin
      if (vif.frame_start === 1'b1) fs_count++;
      if (vif.pix_valid !== 1'b1 && vif.pix_data !== 1'b0) px_bad++;
      if (vif.pix_valid === 1'b1) begin
        vcount++;
        if (sbq.size() == 0) px_bad++;
        else begin
          e = sbq.pop_front();
          if ({vif.pix_x, vif.pix_y, vif.pix_data} !== e) px_bad++;
        end
      end
    end
  end

  task automatic drive_px(input logic h, input logic v, input logic vid, input int x, input int y);
    @(negedge clk_25mhz);
    vif.hsync = h; vif.vsync = v; vif.video = vid;
    if (h && !last_h) begin
      hs_cyc = cyc;
      if (stretched) begin mark_cyc = cyc; stretched = 0; end
    end
    if (v && !last_v) vs_cyc = cyc;
    last_h = h; last_v = v;
    if (chk_on && x < HD && y < VD) sbq.push_back({10'(x), 10'(y), vid});
  endtask

  task automatic drive_line(input int y, input bit stretch, input int ncols);
    logic v;
    v = y >= VD + VF && y < VD + VF + VS;
    for (int x = 0; x < ncols; x++) drive_px(x >= HD + HF && x < HD + HF + HS, v, pat(x, y), x, y);
    if (stretch) begin drive_px(1'b0, v, 1'b0, HT, y); stretched = 1; end
  endtask

  task automatic drive_frame(input int nlines, input int stretch_at);
    for (int y = 0; y < nlines; y++) drive_line(y, y == stretch_at, HT);
  endtask

  task automatic expect_lock_after(input int nframes, input string name);
    for (int f = 0; f < nframes; f++) begin
      drive_frame(VT, -1);
      if (f == nframes - 2) begin
        n_chk++;
        if (vif.locked !== 1'b0) begin n_fail++; $display("FAIL %s early_lock: locked=%b expected 0", name, vif.locked); end
      end
    end
    n_chk++;
    if (vif.locked !== 1'b1) begin n_fail++; $display("FAIL %s lock: locked=%b expected 1", name, vif.locked); end
    n_chk++;
    if (lock_cyc !== vs_cyc + 2) begin n_fail++; $display("FAIL %s lock_time: rose at %0d expected %0d", name, lock_cyc, vs_cyc + 2); end
  endtask

  task automatic test_frame_data(input string name);
    vcount = 0; fs_count = 0; px_bad = 0; sbq.delete();
    chk_on = 1;
    drive_frame(VT, -1);
    chk_on = 0;
    n_chk++;
    if (px_bad !== 0) begin n_fail++; $display("FAIL %s pixels: %0d bad pixels expected 0", name, px_bad); end
    n_chk++;
    if (vcount !== HD * VD) begin n_fail++; $display("FAIL %s valid_count: got %0d expected %0d", name, vcount, HD * VD); end
    n_chk++;
    if (fs_count !== 1) begin n_fail++; $display("FAIL %s frame_start: got %0d expected 1", name, fs_count); end
    n_chk++;
    if (sbq.size() !== 0) begin n_fail++; $display("FAIL %s missing: %0d pixels never output expected 0", name, sbq.size()); end
    sbq.delete();
  endtask

  task automatic test_reset();
    vif.hsync = 0; vif.vsync = 0; vif.video = 0;
    reset_n = 0;
    repeat (3) @(negedge clk_25mhz);
    n_chk++;
    if ({vif.locked, vif.pix_valid, vif.pix_data, vif.frame_start, vif.sync_err} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 00000", {vif.locked, vif.pix_valid, vif.pix_data, vif.frame_start, vif.sync_err});
    end
    n_chk++;
    if ({vif.pix_x, vif.pix_y} !== 20'd0) begin n_fail++; $display("FAIL reset_pos: x=%0d y=%0d expected 0 0", vif.pix_x, vif.pix_y); end
    n_chk++;
    if ({vif.h_total_meas, vif.v_total_meas} !== 20'd0) begin
      n_fail++; $display("FAIL reset_meas: h=%0d v=%0d expected 0 0", vif.h_total_meas, vif.v_total_meas);
    end
    reset_n = 1;
  endtask

  task automatic test_lock();
    expect_lock_after(3, "nominal");
    n_chk++;
    if (vif.h_total_meas !== 10'(HT)) begin n_fail++; $display("FAIL h_total: got %0d expected %0d", vif.h_total_meas, HT); end
    n_chk++;
    if (vif.v_total_meas !== 10'(VT)) begin n_fail++; $display("FAIL v_total: got %0d expected %0d", vif.v_total_meas, VT); end
    test_frame_data("locked_frame1");
    test_frame_data("locked_frame2");
    n_chk++;
    if (err_n !== 0) begin n_fail++; $display("FAIL nominal_err: %0d sync_err pulses expected 0", err_n); end
  endtask

  task automatic test_stretch();
    int e0;
    e0 = err_n;
    drive_frame(VT, 5);
    n_chk++;
    if (err_n !== e0 + 1) begin n_fail++; $display("FAIL stretch_err_count: got %0d expected %0d", err_n - e0, 1); end
    n_chk++;
    if (err_cyc !== mark_cyc + 2) begin n_fail++; $display("FAIL stretch_err_time: at %0d expected %0d", err_cyc, mark_cyc + 2); end
    n_chk++;
    if (err_htm !== 10'(HT + 1)) begin n_fail++; $display("FAIL stretch_h_total: got %0d expected %0d", err_htm, HT + 1); end
    n_chk++;
    if (vif.locked !== 1'b0) begin n_fail++; $display("FAIL stretch_unlock: locked=%b expected 0", vif.locked); end
    expect_lock_after(2, "stretch_relock");
    test_frame_data("after_relock");
  endtask

  task automatic test_timeout();
    int e0;
    e0 = err_n;
    for (int y = 0; y < 3; y++) drive_line(y, 1'b0, HT);
    for (int i = 0; i < 1100; i++) drive_px(1'b0, 1'b0, 1'b0, HT, 0);
    n_chk++;
    if (err_n !== e0 + 1) begin n_fail++; $display("FAIL timeout_err_count: got %0d expected 1", err_n - e0); end
    n_chk++;
    if (err_cyc !== hs_cyc + 1024) begin n_fail++; $display("FAIL timeout_time: at %0d expected %0d", err_cyc, hs_cyc + 1024); end
    n_chk++;
    if (err_htm !== 10'd1023 || vif.h_total_meas !== 10'd1023) begin
      n_fail++; $display("FAIL timeout_h_total: got %0d/%0d expected 1023", err_htm, vif.h_total_meas);
    end
    n_chk++;
    if (vif.locked !== 1'b0) begin n_fail++; $display("FAIL timeout_unlock: locked=%b expected 0", vif.locked); end
    expect_lock_after(3, "timeout_relock");
  endtask

  task automatic test_short_frame();
    int e0;
    e0 = err_n;
    drive_frame(VT - 1, -1);
    n_chk++;
    if (err_n !== e0) begin n_fail++; $display("FAIL short_early_err: got %0d expected 0", err_n - e0); end
    drive_frame(VT, -1);
    n_chk++;
    if (err_n !== e0 + 1 || err_cyc !== vs_cyc + 2) begin
      n_fail++; $display("FAIL short_err: count %0d at %0d expected 1 at %0d", err_n - e0, err_cyc, vs_cyc + 2);
    end
    n_chk++;
    if (err_vtm !== 10'(VT - 1) || vif.v_total_meas !== 10'(VT - 1)) begin
      n_fail++; $display("FAIL short_v_total: got %0d/%0d expected %0d", err_vtm, vif.v_total_meas, VT - 1);
    end
    n_chk++;
    if (vif.locked !== 1'b0) begin n_fail++; $display("FAIL short_unlock: locked=%b expected 0", vif.locked); end
    expect_lock_after(3, "short_relock");
  endtask

  task automatic test_reset_mid();
    for (int y = 0; y < 10; y++) drive_line(y, 1'b0, HT);
    drive_line(10, 1'b0, 20);
    n_chk++;
    if ({vif.locked, vif.pix_valid} !== 2'b11) begin n_fail++; $display("FAIL mid_pre_reset: locked,valid=%b expected 11", {vif.locked, vif.pix_valid}); end
    #5 reset_n = 0;
    #1;
    n_chk++;
    if ({vif.locked, vif.pix_valid, vif.pix_data, vif.frame_start, vif.sync_err} !== 5'b0) begin
      n_fail++; $display("FAIL mid_reset_flags: got %b expected 00000", {vif.locked, vif.pix_valid, vif.pix_data, vif.frame_start, vif.sync_err});
    end
    n_chk++;
    if ({vif.pix_x, vif.pix_y, vif.h_total_meas, vif.v_total_meas} !== 40'd0) begin
      n_fail++; $display("FAIL mid_reset_regs: x=%0d y=%0d h=%0d v=%0d expected all 0", vif.pix_x, vif.pix_y, vif.h_total_meas, vif.v_total_meas);
    end
    vif.hsync = 0; vif.vsync = 0; vif.video = 0; last_h = 0; last_v = 0;
    repeat (2) @(negedge clk_25mhz);
    reset_n = 1;
    expect_lock_after(3, "post_reset_relock");
  endtask

  initial begin
    test_reset();
    test_lock();
    test_stretch();
    test_timeout();
    test_short_frame();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
